// File: rtl/dpm_pkg.sv
// dpm_pkg: state encodings and averaging constants shared by delay_path_meter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dpm_pkg;

    // Measurement sequencer states
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_LAUNCH_R = 3'd1;
    localparam logic [2:0] ST_WAIT_R   = 3'd2;
    localparam logic [2:0] ST_LAUNCH_F = 3'd3;
    localparam logic [2:0] ST_WAIT_F   = 3'd4;
    localparam logic [2:0] ST_REPORT   = 3'd5;

    // Averaging: number of rise/fall runs per start and its log2
    localparam int AVG_RUNS  = 8;
    localparam int AVG_SHIFT = 3;

    // Depth of the return-path synchronizer; it is also the smallest
    // count a measurement can produce, since the first samples seen in a
    // WAIT state were taken before the launch edge left the chip.
    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/dpm_sync.sv
// dpm_sync: two-flop synchronizer for one asynchronous bit.
// Latency: 2 clk cycles from d_i to q_o.
// Backpressure: none; samples every cycle.
module dpm_sync (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture; the first flop may go metastable, the second resolves it
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/delay_path_meter.sv
// delay_path_meter: measures rise and fall delay of one external chain per start; DPM_AVG_EN averages 8 runs.
// Latency: about rise+fall delay + 6 cycles per run (counts include 2 sync stages), capped by TIMEOUT per edge.
// Backpressure: none; start is accepted only in IDLE and ignored while busy.
module delay_path_meter
    import dpm_pkg::*;
#(
    parameter  int CHANNELS = 4,
    parameter  int CNT_W    = 16,
    parameter  int TIMEOUT  = 1023,
    localparam int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [SEL_W-1:0]    ch_sel,
    output logic [CHANNELS-1:0] path_launch,
    input  logic [CHANNELS-1:0] path_return,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    rise_cnt,
    output logic [CNT_W-1:0]    fall_cnt,
    output logic                timeout
);

    localparam logic [CNT_W-1:0] TO_V   = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] MIN_V  = CNT_W'(SYNC_STAGES);

    logic [2:0]          state_q,   state_d;
    logic [SEL_W-1:0]    ch_q,      ch_d;
    logic [CHANNELS-1:0] launch_q,  launch_d;
    logic [CNT_W-1:0]    cnt_q,     cnt_d;
    logic [CNT_W-1:0]    rise_q,    rise_d;
    logic [CNT_W-1:0]    fall_q,    fall_d;
    logic                timeout_q, timeout_d;
    logic                to_run_q,  to_run_d;

    logic [CHANNELS-1:0] ret_sync;
    logic [SEL_W-1:0]    ch_sel_safe;
    logic                ret_ch;
    logic                target;
    logic                hit;
    logic                expire;

`ifdef DPM_AVG_EN
    localparam int ACC_W = CNT_W + AVG_SHIFT;
    localparam logic [AVG_SHIFT-1:0] LAST_RUN = AVG_SHIFT'(AVG_RUNS - 1);

    logic [AVG_SHIFT-1:0] run_q,      run_d;
    logic [ACC_W-1:0]     rise_acc_q, rise_acc_d;
    logic [ACC_W-1:0]     fall_acc_q, fall_acc_d;
    logic [ACC_W-1:0]     fall_sum;

    assign fall_sum = fall_acc_q + ACC_W'(cnt_q);
`endif

    genvar g;
    generate
        for (g = 0; g < CHANNELS; g++) begin : g_sync
            dpm_sync u_sync (
                .clk (clk),
                .rst (rst),
                .d_i (path_return[g]),
                .q_o (ret_sync[g])
            );
        end
    endgenerate

    // Out-of-range channel requests fall back to channel 0
    assign ch_sel_safe = (int'(ch_sel) < CHANNELS) ? ch_sel : '0;

    // Edge detection for the channel under test: samples younger than the
    // synchronizer depth predate the launch edge and are not trusted.
    // A return that lands exactly on the TIMEOUT count still counts as a hit.
    assign ret_ch = ret_sync[ch_q];
    assign target = (state_q == ST_WAIT_R);
    assign hit    = (ret_ch == target) && (cnt_q >= MIN_V);
    assign expire = !hit && (cnt_q == TO_V);

    // Sequencer next-state and datapath updates
    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        launch_d  = launch_q;
        cnt_d     = cnt_q;
        rise_d    = rise_q;
        fall_d    = fall_q;
        timeout_d = timeout_q;
        to_run_d  = to_run_q;
`ifdef DPM_AVG_EN
        run_d      = run_q;
        rise_acc_d = rise_acc_q;
        fall_acc_d = fall_acc_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ch_d      = ch_sel_safe;
                    timeout_d = 1'b0;
                    to_run_d  = 1'b0;
`ifdef DPM_AVG_EN
                    run_d      = '0;
                    rise_acc_d = '0;
                    fall_acc_d = '0;
`endif
                    state_d   = ST_LAUNCH_R;
                end
            end

            ST_LAUNCH_R: begin
                launch_d       = '0;
                launch_d[ch_q] = 1'b1;
                cnt_d          = '0;
                state_d        = ST_WAIT_R;
            end

            ST_WAIT_R: begin
                if (hit || expire) begin
                    // cnt_q already equals TIMEOUT on expiry, so it is the stored value either way
`ifdef DPM_AVG_EN
                    rise_acc_d = rise_acc_q + ACC_W'(cnt_q);
`else
                    rise_d     = cnt_q;
`endif
                    if (expire) begin
                        to_run_d = 1'b1;
                        // Drop the launch now so the chain starts settling low
                        launch_d = '0;
                    end
                    state_d = ST_LAUNCH_F;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_LAUNCH_F: begin
                launch_d = '0;
                cnt_d    = '0;
                state_d  = ST_WAIT_F;
            end

            ST_WAIT_F: begin
                if (hit || expire) begin
`ifdef DPM_AVG_EN
                    fall_acc_d = fall_sum;
                    if (expire) begin
                        to_run_d = 1'b1;
                    end
                    if (run_q == LAST_RUN) begin
                        rise_d    = rise_acc_q[AVG_SHIFT +: CNT_W];
                        fall_d    = fall_sum[AVG_SHIFT +: CNT_W];
                        timeout_d = to_run_q | expire;
                        state_d   = ST_REPORT;
                    end else begin
                        run_d   = run_q + 1'b1;
                        state_d = ST_LAUNCH_R;
                    end
`else
                    fall_d    = cnt_q;
                    timeout_d = to_run_q | expire;
                    state_d   = ST_REPORT;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_REPORT: begin
                state_d = ST_IDLE;
            end

            default: begin
                launch_d = '0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // State and result registers; reset aborts any run without a done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ch_q      <= '0;
            launch_q  <= '0;
            cnt_q     <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            timeout_q <= 1'b0;
            to_run_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            launch_q  <= launch_d;
            cnt_q     <= cnt_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            timeout_q <= timeout_d;
            to_run_q  <= to_run_d;
        end
    end

`ifdef DPM_AVG_EN
    // Run counter and per-edge accumulators for the averaged build
    always_ff @(posedge clk) begin
        if (rst) begin
            run_q      <= '0;
            rise_acc_q <= '0;
            fall_acc_q <= '0;
        end else begin
            run_q      <= run_d;
            rise_acc_q <= rise_acc_d;
            fall_acc_q <= fall_acc_d;
        end
    end
`endif

    assign path_launch = launch_q;
    assign busy        = (state_q != ST_IDLE) && (state_q != ST_REPORT);
    assign done        = (state_q == ST_REPORT);
    assign rise_cnt    = rise_q;
    assign fall_cnt    = fall_q;
    assign timeout     = timeout_q;

endmodule
